// File: rtl/bcd2bin_mru.sv
// bcd2bin_mru
//   Rebuilds a 16-bit binary value from a 5-digit packed BCD word, one digit
//   per enabled clock, most-significant digit first (acc = acc*10 + digit).
//   A set/getData handshake moves each conversion through IDLE, CONV and DONE.
//   An optional cooldown of MAX_RATE enabled cycles follows each getData.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   set      in   1   start request, accepted in IDLE when ready
//   data     in   20  packed BCD, [19:16] = ten-thousands ... [3:0] = units
//   getData  in   1   consumer acknowledge, acted on in DONE
//   enable   in   1   clock enable; 0 holds every piece of state
//   dataOut  out  16  binary result (16'hFFFF when err)
//   valid    out  1   result available
//   err      out  1   bad digit or value above 65535; qualified by valid
//   ready    out  1   idle and cooldown expired
module bcd2bin_mru #(
  parameter int unsigned MAX_RATE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set,
  input  logic [19:0] data,
  input  logic        getData,
  input  logic        enable,
  output logic [15:0] dataOut,
  output logic        valid,
  output logic        err,
  output logic        ready
);

  localparam int unsigned CW = (MAX_RATE > 0) ? $clog2(MAX_RATE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2,
    COOL = 2'd3
  } state_t;

  state_t          state;
  logic [19:0]     shift;
  logic [16:0]     acc;
  logic [2:0]      digit_cnt;
  logic            bad;
  logic [CW-1:0]   cool_cnt;

  // Next-digit arithmetic; *10 is built as (acc<<3)+(acc<<1).
  logic [3:0]      digit;
  logic [16:0]     acc_next;
  logic            bad_next;
  logic            ovf;

  always_comb begin
    digit    = shift[19:16];
    acc_next = (acc << 3) + (acc << 1) + {13'd0, digit};
    bad_next = bad | (digit > 4'd9);
    ovf      = acc_next[16];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      acc       <= '0;
      digit_cnt <= '0;
      bad       <= 1'b0;
      cool_cnt  <= '0;
      dataOut   <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      ready     <= 1'b1;
    end else if (enable) begin
      unique case (state)
        IDLE: begin
          if (set) begin
            shift     <= data;
            acc       <= '0;
            digit_cnt <= '0;
            bad       <= 1'b0;
            ready     <= 1'b0;
            state     <= CONV;
          end
        end
        CONV: begin
          acc   <= acc_next;
          shift <= shift << 4;
          bad   <= bad_next;
          if (digit_cnt == 3'd4) begin
            // Result is committed on the same edge that consumes the last digit.
            err     <= bad_next | ovf;
            dataOut <= (bad_next | ovf) ? 16'hFFFF : acc_next[15:0];
            valid   <= 1'b1;
            state   <= DONE;
          end else begin
            digit_cnt <= digit_cnt + 3'd1;
          end
        end
        DONE: begin
          if (getData) begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (MAX_RATE == 0) begin
              ready <= 1'b1;
              state <= IDLE;
            end else begin
              cool_cnt <= CW'(MAX_RATE);
              state    <= COOL;
            end
          end
        end
        COOL: begin
          // Leaving on the decrement that reaches zero keeps ready low for
          // exactly MAX_RATE enabled cycles after the acknowledge.
          if (cool_cnt <= CW'(1)) begin
            cool_cnt <= '0;
            ready    <= 1'b1;
            state    <= IDLE;
          end else begin
            cool_cnt <= cool_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_mru.sv
module tb_bcd2bin_mru;

  logic        clk;
  logic        rst_n;
  logic        set;
  logic [19:0] data;
  logic        getData;
  logic        enable;

  logic [15:0] dout0, dout3;
  logic        valid0, valid3, err0, err3, ready0, ready3;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [16:0] q0[$];
  logic [16:0] q3[$];
  logic        prev0, prev3;

  bcd2bin_mru #(.MAX_RATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .set(set), .data(data), .getData(getData),
    .enable(enable), .dataOut(dout0), .valid(valid0), .err(err0), .ready(ready0)
  );

  bcd2bin_mru #(.MAX_RATE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .set(set), .data(data), .getData(getData),
    .enable(enable), .dataOut(dout3), .valid(valid3), .err(err3), .ready(ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain positional BCD decode, {err, value}.
  function automatic logic [16:0] model(input logic [19:0] d);
    int unsigned v = 0;
    bit b = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      int unsigned dig = int'(d[i*4 +: 4]);
      if (dig > 9) b = 1'b1;
      v = v * 10 + dig;
    end
    if (b || v > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, 16'(v)};
  endfunction

  // Output monitors: a rising valid pops the next expected result.
  always @(negedge clk) begin
    if (valid0 && !prev0) begin
      if (q0.size() == 0) check_eq("dut0_unexpected_valid", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = q0.pop_front();
        check_eq("dut0_data", {16'd0, dout0}, {16'd0, e[15:0]});
        check_eq("dut0_err", {31'd0, err0}, {31'd0, e[16]});
      end
    end
    prev0 <= valid0;
  end

  always @(negedge clk) begin
    if (valid3 && !prev3) begin
      if (q3.size() == 0) check_eq("dut3_unexpected_valid", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = q3.pop_front();
        check_eq("dut3_data", {16'd0, dout3}, {16'd0, e[15:0]});
        check_eq("dut3_err", {31'd0, err3}, {31'd0, e[16]});
      end
    end
    prev3 <= valid3;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(ready0 && ready3) && n < 50) begin
      step();
      n++;
    end
    if (!(ready0 && ready3)) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic start(input logic [19:0] d);
    wait_ready();
    q0.push_back(model(d));
    q3.push_back(model(d));
    set  = 1'b1;
    data = d;
    step();
    set  = 1'b0;
  endtask

  task automatic wait_valid(inout int lat);
    while (!valid0 && lat < 40) begin
      step();
      lat++;
    end
    if (!valid0) check_eq("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack();
    getData = 1'b1;
    step();
    getData = 1'b0;
  endtask

  task automatic run_conv(input logic [19:0] d, output int lat);
    lat = 0;
    start(d);
    wait_valid(lat);
  endtask

  logic [19:0] tbl [5] = '{20'h65535, 20'h65536, 20'h00000, 20'h99999, 20'h0A123};

  initial begin
    int lat;
    logic [15:0] snap;
    logic [19:0] rd;

    rst_n = 1'b0; set = 1'b0; data = '0; getData = 1'b0; enable = 1'b1;
    prev0 = 1'b0; prev3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, valid0}, 32'd0);
    check_eq("rst_err", {31'd0, err0}, 32'd0);
    check_eq("rst_data", {16'd0, dout0}, 32'd0);
    check_eq("rst_ready0", {31'd0, ready0}, 32'd1);
    check_eq("rst_ready3", {31'd0, ready3}, 32'd1);
    rst_n = 1'b1;
    step();

    // Basic conversion and latency.
    run_conv(20'h65233, lat);
    check_eq("t1_latency", lat, 32'd5);
    check_eq("t1_data", {16'd0, dout0}, 32'h0000FED1);
    check_eq("t1_err", {31'd0, err0}, 32'd0);
    ack();
    check_eq("t1_valid_low", {31'd0, valid0}, 32'd0);
    check_eq("t1_ready", {31'd0, ready0}, 32'd1);
    check_eq("t1_data_kept", {16'd0, dout0}, 32'h0000FED1);

    // Boundaries and bad digits.
    foreach (tbl[i]) begin
      run_conv(tbl[i], lat);
      ack();
    end
    run_conv(20'h0A123, lat);
    check_eq("t3_err", {31'd0, err0}, 32'd1);
    check_eq("t3_data", {16'd0, dout0}, 32'h0000FFFF);
    ack();

    // Stall mid-conversion, then stall in DONE.
    start(20'h01234);
    step();
    lat = 1;
    snap = dout0;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      lat++;
      check_eq("t4_stall_valid", {31'd0, valid0}, 32'd0);
      check_eq("t4_stall_data", {16'd0, dout0}, {16'd0, snap});
    end
    enable = 1'b1;
    wait_valid(lat);
    check_eq("t4_latency", lat, 32'd8);
    check_eq("t4_data", {16'd0, dout0}, 32'h000004D2);
    enable = 1'b0;
    getData = 1'b1;
    step();
    check_eq("t4_done_stall_valid", {31'd0, valid0}, 32'd1);
    enable = 1'b1;
    step();
    getData = 1'b0;
    check_eq("t4_ack_valid", {31'd0, valid0}, 32'd0);

    // set re-pulsed during CONV and DONE; cooldown on the MAX_RATE=3 unit.
    start(20'h00777);
    step();
    set = 1'b1; data = 20'h12345;
    step();
    set = 1'b0; data = '0;
    lat = 2;
    wait_valid(lat);
    check_eq("t5_no_restart", {16'd0, dout0}, 32'h00000309);
    set = 1'b1; data = 20'h11111; getData = 1'b1;
    step();
    set = 1'b0; getData = 1'b0;
    check_eq("t5_valid_low", {31'd0, valid0}, 32'd0);
    check_eq("t5_cool0", {31'd0, ready3}, 32'd0);
    step();
    check_eq("t5_cool1", {31'd0, ready3}, 32'd0);
    step();
    check_eq("t5_cool2", {31'd0, ready3}, 32'd0);
    step();
    check_eq("t5_cool_done", {31'd0, ready3}, 32'd1);
    repeat (6) step();
    check_eq("t5_no_conv", {31'd0, valid0}, 32'd0);
    run_conv(20'h00100, lat);
    check_eq("t5_accept3", {16'd0, dout3}, 32'h00000064);
    ack();

    // Reset mid-conversion.
    wait_ready();
    set = 1'b1; data = 20'h54321;
    step();
    set = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", {31'd0, valid0}, 32'd0);
    check_eq("t6_rst_err", {31'd0, err0}, 32'd0);
    check_eq("t6_rst_data", {16'd0, dout0}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check_eq("t6_ready0", {31'd0, ready0}, 32'd1);
    check_eq("t6_ready3", {31'd0, ready3}, 32'd1);
    check_eq("t6_valid3", {31'd0, valid3}, 32'd0);
    run_conv(20'h00042, lat);
    check_eq("t6_data", {16'd0, dout0}, 32'h0000002A);
    ack();

    // Random BCD words.
    for (int k = 0; k < 8; k++) begin
      rd = '0;
      for (int j = 0; j < 5; j++) rd[j*4 +: 4] = 4'($urandom_range(0, 9));
      run_conv(rd, lat);
      ack();
    end

    repeat (8) step();
    check_eq("q0_drained", q0.size(), 32'd0);
    check_eq("q3_drained", q3.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
